core_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core datapath. It sits between the combinational `Control_unit` and the state elements: PC, instruction register, register file and data memory port. It steps each instruction through FETCH/DECODE/EXEC/MEM phases against handshaked instruction and data memories. It gates the decoder's write strobes so they fire only in the correct cycle, counts retired instructions, and traps illegal opcodes and memory timeouts.

---
 rtl/core_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_core_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the RV32I core datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM, gates the decoder's
// write strobes into the single cycle where they may take effect, counts
// retired instructions and traps illegal opcodes and memory timeouts.
//
// Handshake: a request (imem_req/dmem_req) is raised on entry to its wait
// state and held every cycle until the matching ack is seen high on a rising
// edge; the ack completes the access in that same cycle. Acks seen while the
// sequencer is not waiting on that memory are ignored.
module core_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             RegWrite_cu,
    input  logic             MemWrite_cu,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             Err,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EXEC   = 3'b011;
    localparam logic [2:0] S_MEM    = 3'b100;
    localparam logic [2:0] S_ERR    = 3'b111;

    // Wait counter only ever needs to reach TIMEOUT-1 before the FSM leaves.
    localparam int              WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic              err;
    logic              op_legal;
    logic              op_mem;
    logic              retire;
    logic              wait_stay;

    // Opcode classification for the DECODE branch.
    always_comb begin
        op_legal = 1'b0;
        op_mem   = 1'b0;
        case (op)
            7'b0000011,
            7'b0100011: begin
                op_legal = 1'b1;
                op_mem   = 1'b1;
            end
            7'b0010011,
            7'b0010111,
            7'b0110011,
            7'b0110111,
            7'b1100011,
            7'b1100111,
            7'b1101111: op_legal = 1'b1;
            default: begin
                op_legal = 1'b0;
                op_mem   = 1'b0;
            end
        endcase
    end

    // Next-state logic plus all strobes, purely from state and inputs.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    IRWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_DECODE: begin
                if (!op_legal)   state_next = S_ERR;
                else if (op_mem) state_next = S_MEM;
                else             state_next = S_EXEC;
            end
            S_EXEC: begin
                RegWrite   = RegWrite_cu;
                PCWrite    = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                MemWrite = MemWrite_cu;
                if (dmem_ack) begin
                    RegWrite   = RegWrite_cu;
                    PCWrite    = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = S_ERR;
                end
            end
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
    end

    // Counter runs only while the FSM stays in a wait state; any entry clears it.
    assign wait_stay = (state_next == state) && ((state == S_FETCH) || (state == S_MEM));

    // State register and sticky fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_ERR) err <= 1'b1;
        end
    end

    // Memory wait counter for timeout detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            wait_cnt <= '0;
        else if (wait_stay) wait_cnt <= wait_cnt + WAIT_W'(1);
        else                wait_cnt <= '0;
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instr_cnt <= '0;
        else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end

    assign State    = state;
    assign Err      = err;
    assign InstrCnt = instr_cnt;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed phase-by-phase stimulus, expected output
// vectors queued by the driver and compared by an independent negedge monitor.
module tb_core_seq_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int W       = 14;

    localparam logic [2:0] S_IDLE   = 3'b000;
    localparam logic [2:0] S_FETCH  = 3'b001;
    localparam logic [2:0] S_DECODE = 3'b010;
    localparam logic [2:0] S_EXEC   = 3'b011;
    localparam logic [2:0] S_MEM    = 3'b100;
    localparam logic [2:0] S_ERR    = 3'b111;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BAD  = 7'b0000000;

    logic             clk;
    logic             rst;
    logic [6:0]       op;
    logic             RegWrite_cu;
    logic             MemWrite_cu;
    logic             imem_ack;
    logic             dmem_ack;
    logic             imem_req;
    logic             dmem_req;
    logic             IRWrite;
    logic             PCWrite;
    logic             RegWrite;
    logic             MemWrite;
    logic             Err;
    logic [2:0]       State;
    logic [CNT_W-1:0] InstrCnt;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [CNT_W-1:0] exp_cnt;
    int           checks;
    int           errors;

    core_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .op(op), .RegWrite_cu(RegWrite_cu),
        .MemWrite_cu(MemWrite_cu), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .Err(Err), .State(State), .InstrCnt(InstrCnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {imem_req,dmem_req,IRWrite,PCWrite,RegWrite,MemWrite,Err,State,InstrCnt}
    function automatic logic [W-1:0] mk(input logic ireq, input logic dreq, input logic irw,
                                        input logic pcw, input logic rw, input logic mw,
                                        input logic er, input logic [2:0] st,
                                        input logic [CNT_W-1:0] cnt);
        return {ireq, dreq, irw, pcw, rw, mw, er, st, cnt};
    endfunction

    // Driver tasks: one call = one clock cycle of stimulus plus its expectation.
    task automatic drive(input logic ia, input logic da, input logic rwc, input logic mwc,
                         input logic [W-1:0] ev, input string nm);
        @(posedge clk);
        #1;
        imem_ack    = ia;
        dmem_ack    = da;
        RegWrite_cu = rwc;
        MemWrite_cu = mwc;
        exp_q.push_back(ev);
        name_q.push_back(nm);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0; RegWrite_cu = 1'b0; MemWrite_cu = 1'b0;
        exp_cnt = '0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_IDLE, '0));
        name_q.push_back("reset_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_IDLE, '0));
        name_q.push_back("idle");
    endtask

    task automatic fetch_wait(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 0, 0, S_FETCH, exp_cnt), "fetch_wait");
    endtask

    task automatic fetch(input int nw);
        fetch_wait(nw);
        drive(1'b1, 1'b1, 1'b1, 1'b1, mk(1, 0, 1, 0, 0, 0, 0, S_FETCH, exp_cnt), "fetch_ack");
    endtask

    task automatic decode(input logic [6:0] o, input logic rwc, input logic mwc);
        op = o;
        drive(1'b1, 1'b1, rwc, mwc, mk(0, 0, 0, 0, 0, 0, 0, S_DECODE, exp_cnt), "decode");
    endtask

    task automatic exec(input logic rwc);
        drive(1'b1, 1'b1, rwc, 1'b1, mk(0, 0, 0, 1, rwc, 0, 0, S_EXEC, exp_cnt), "exec");
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic mem_wait(input int n, input logic rwc, input logic mwc);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b0, rwc, mwc, mk(0, 1, 0, 0, 0, mwc, 0, S_MEM, exp_cnt), "mem_wait");
    endtask

    task automatic mem(input int nw, input logic rwc, input logic mwc);
        mem_wait(nw, rwc, mwc);
        drive(1'b1, 1'b1, rwc, mwc, mk(0, 1, 0, 1, rwc, mwc, 0, S_MEM, exp_cnt), "mem_ack");
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic err_cycles(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b1, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0, 1, S_ERR, exp_cnt), "err_hold");
    endtask

    // Scoreboard monitor: pops one expectation per sampled cycle.
    logic [W-1:0] mon_exp;
    logic [W-1:0] mon_act;
    string        mon_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {imem_req, dmem_req, IRWrite, PCWrite, RegWrite, MemWrite, Err, State, InstrCnt};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL %s at %0t: got %b expected %b", mon_name, $time, mon_act, mon_exp);
            end
        end
    end

    // Directed scenarios
    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; op = OP_ADDI; RegWrite_cu = 1'b0; MemWrite_cu = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; exp_cnt = '0;

        // Reset then ADDI, SW with 3 MEM cycles, LW with one fetch wait
        do_reset();
        fetch(0); decode(OP_ADDI, 1'b1, 1'b0); exec(1'b1);
        fetch(0); decode(OP_SW, 1'b0, 1'b1); mem(2, 1'b0, 1'b1);
        fetch(1); decode(OP_LW, 1'b1, 1'b0); mem(0, 1'b1, 1'b0);
        // Fetch ack on the last permitted cycle still wins
        fetch(TIMEOUT - 1); decode(OP_LUI, 1'b1, 1'b0); exec(1'b1);
        fetch(0); decode(OP_BEQ, 1'b0, 1'b0); exec(1'b0);
        // Fetch withheld for the full window -> ERR, acks ignored afterwards
        fetch_wait(TIMEOUT);
        err_cycles(3);

        // Illegal opcode
        do_reset();
        fetch(0); decode(OP_BAD, 1'b1, 1'b1);
        err_cycles(3);

        // Data memory timeout
        do_reset();
        fetch(0); decode(OP_SW, 1'b0, 1'b1);
        mem_wait(TIMEOUT, 1'b0, 1'b1);
        err_cycles(2);

        // Reset in the middle of a MEM wait
        do_reset();
        fetch(0); decode(OP_JAL, 1'b1, 1'b0); exec(1'b1);
        fetch(0); decode(OP_LW, 1'b1, 1'b0); mem_wait(2, 1'b1, 1'b0);
        do_reset();

        // Sixteen retirements wrap the 4-bit counter back to 0
        for (int i = 0; i < 16; i++) begin
            fetch(i % 2);
            if (i % 3 == 0) begin
                decode(OP_LW, 1'b1, 1'b0); mem(i % 2, 1'b1, 1'b0);
            end else begin
                decode(OP_ADDI, 1'b1, 1'b0); exec(1'b1);
            end
        end
        fetch(0);

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
